udp_payload_buffer: RTL and testbench
=====================================

# udp_payload_buffer

Upstream payload stage for the GMII UDP transmitter. Accepts one UDP payload as a byte stream, packs it big-endian into 32-bit words in a 512×32 RAM, and derives the UDP and IPv4 length fields. It serves the transmitter's word reads through `ram_rd_addr`/`datain`. It tracks the transmitter's `tx_state` so that a committed frame is never overwritten while it is being sent.

## Interface
- `MAX_BYTES`, default 1472: payload byte limit. Must be ≤ 2044 (511 words × 4).
- `clk`  in  1: single clock. The transmitter runs on the negedge of the same clock.
- `rst`  in  1: synchronous, active-high reset.
- `s_data`  in  8: payload byte.
- `s_valid`  in  1: `s_data` is valid.
- `s_last`  in  1: last byte of the payload, qualified by `s_valid`.
- `s_ready`  out  1: byte is accepted when `s_valid && s_ready`.
- `tx_state`  in  4: transmitter state. 0 = idle, 7 = sendcrc.
- `ram_rd_addr`  in  9: transmitter word read address.
- `datain`  out  32: RAM read data, registered.
- `tx_data_length`  out  16: UDP length, 8 + payload bytes.
- `tx_total_length`  out  16: IPv4 total length, 28 + payload bytes.
- `frame_ready`  out  1: a committed frame is waiting for the transmitter.
- `overflow`  out  1: one-cycle pulse when a byte is dropped beyond `MAX_BYTES`.

## Operation
- States:
  - FILL: the only state that accepts bytes.
  - COMMIT: one cycle, publishes the lengths.
  - HOLD: waiting for the transmitter to start.
  - BUSY: transmitter is sending.
- Packing:
  - Byte n goes to word address 1 + n/4, lane n%4.
  - Lane 0 is bits [31:24].
  - Word 0 is never written; payload starts at address 1 because the transmitter's first read is address 1.
- Word write occurs on the 4th byte of a word, or on `s_last`.
- On `s_last`, unused low lanes of the final word are written as zero.
- Byte counter is 12 bits. Lengths are computed with 16-bit unsigned arithmetic and never wrap, since `MAX_BYTES` is ≤ 2044.
- Bytes accepted after count = `MAX_BYTES`:
  - They are dropped and are not written.
  - `overflow` pulses once per dropped byte.
  - The frame still commits on `s_last` with count = `MAX_BYTES`.
- Transitions:
  - FILL→COMMIT: `s_last` accepted.
  - COMMIT→HOLD: always.
  - HOLD→BUSY: `tx_state` ≠ 0.
  - BUSY→FILL: `tx_state` == 7 sampled, followed by `tx_state` == 0.
- If `tx_state` ≠ 0 while in FILL, the transmitter is sending the previous frame:
  - `s_ready` is held low until `tx_state` returns to 0.
  - Partially collected bytes are kept.
- Next-frame collection begins only in FILL. Lengths are not updated until COMMIT, so they stay stable throughout BUSY.

## Timing
- `s_ready` = (state == FILL) && (`tx_state` == 0), registered from the previous cycle's state.
- Write to RAM takes effect the cycle after the byte is accepted.
- `datain` = RAM[`ram_rd_addr`] sampled at posedge `clk`. This gives a half-cycle setup before the transmitter's negedge use.
- COMMIT is one cycle after the `s_last` handshake.
- `tx_data_length`, `tx_total_length` and `frame_ready` update at the end of COMMIT.
- `frame_ready` is high in HOLD and low in all other states.
- Reset values:
  - state FILL.
  - `s_ready` 0 for the reset cycle, then 1.
  - `datain` 0.
  - `tx_data_length` 16'd26 and `tx_total_length` 16'd46 (18-byte frame).
  - `frame_ready` 0, `overflow` 0, counters 0.
  - RAM contents not reset.
- Reset mid-frame: the partial frame is discarded and the state returns to FILL. Lengths revert to their reset values.
- Simultaneous `s_last` and overflow: the dropped byte pulses `overflow` and the frame still commits.

## Configuration
- `UDP_MIN_PAD_EN`, defined:
  - Payloads shorter than 18 bytes are padded with zero bytes to 18, which gives the 64-byte minimum Ethernet frame.
  - FILL→COMMIT inserts the zero words over extra cycles.
  - Lengths report 26/46.
- `UDP_MIN_PAD_EN`, undefined: lengths reflect the true payload; minimum 1 byte (9/29).

## Structure
- Package `udp_tx_pkg` holds:
  - transmitter state codes `TX_IDLE`=4'd0 and `TX_SENDCRC`=4'd7;
  - `UDP_HDR_LEN`=8, `IP_HDR_LEN`=20, `MIN_PAYLOAD`=18, `PAYLOAD_BASE_ADDR`=9'd1;
  - the buffer state enum.
- Sub-module `udp_payload_ram`: 512×32 simple dual-port RAM with one write port and one registered read port, both on `clk`.

## Test plan
- 8 bytes 0x01..0x08, `s_last` on 0x08:
  - RAM[1]=0x01020304 and RAM[2]=0x05060708.
  - Lengths are 16/36 without pad, 26/46 with pad.
  - `frame_ready`=1 two cycles after `s_last`.
- 5 bytes 0xA1..0xA5: RAM[2]=0xA5000000 and the payload count is 5.
- Send `MAX_BYTES`+3 bytes:
  - Three `overflow` pulses.
  - Lengths are 1480/1500.
  - RAM[369] is unmodified beyond the last valid word.
- Drive `tx_state` 0→5→6→7→0 while in HOLD:
  - BUSY is entered.
  - `s_ready`=0 throughout.
  - Lengths are stable.
  - FILL and `s_ready`=1 follow after the return to 0.
- Assert `rst` after 3 bytes: next cycle state is FILL, lengths 26/46, `frame_ready`=0. A fresh frame then packs from address 1.
- Read `ram_rd_addr`=1 after commit: `datain` equals RAM[1] at the next posedge.

Source files
------------

// File: rtl/udp_tx_pkg.sv
// Shared constants and buffer state type for the GMII UDP transmit path.
package udp_tx_pkg;

  localparam logic [3:0] TX_IDLE    = 4'd0;
  localparam logic [3:0] TX_SENDCRC = 4'd7;

  localparam int UDP_HDR_LEN = 8;
  localparam int IP_HDR_LEN  = 20;
  localparam int MIN_PAYLOAD = 18;

  localparam logic [8:0] PAYLOAD_BASE_ADDR = 9'd1;

  typedef enum logic [2:0] {
    ST_FILL   = 3'd0,
    ST_COMMIT = 3'd1,
    ST_HOLD   = 3'd2,
    ST_BUSY   = 3'd3,
    ST_PAD    = 3'd4
  } buf_state_t;

  // Places byte b in the given lane of a big-endian word; lanes below it are zeroed.
  function automatic logic [31:0] pack_lane(input logic [31:0] word, input logic [1:0] lane,
                                            input logic [7:0] b);
    logic [31:0] res;
    case (lane)
      2'd0:    res = {b, 24'h0};
      2'd1:    res = {word[31:24], b, 16'h0};
      2'd2:    res = {word[31:16], b, 8'h0};
      default: res = {word[31:8], b};
    endcase
    return res;
  endfunction

endpackage

// File: rtl/udp_payload_ram.sv
// 512x32 simple dual-port RAM: one write port, one registered read port.
module udp_payload_ram (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [8:0]  wr_addr,
  input  logic [31:0] wr_data,
  input  logic [8:0]  rd_addr,
  output logic [31:0] rd_data
);

  logic [31:0] mem [512];

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) rd_data <= 32'h0;
    else     rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/udp_payload_buffer.sv
// Packs one UDP payload into word RAM and publishes UDP/IPv4 lengths for the transmitter.
// Optional macro UDP_MIN_PAD_EN pads short payloads with zeros to 18 bytes.
//
// state  | meaning
// FILL   | accepting payload bytes (stalled while the transmitter is not idle)
// PAD    | writing zero words up to the minimum payload (UDP_MIN_PAD_EN only)
// COMMIT | one cycle, lengths published
// HOLD   | frame ready, waiting for the transmitter to start
// BUSY   | transmitter sending; wait for SENDCRC then IDLE
module udp_payload_buffer
  import udp_tx_pkg::*;
#(
  parameter int MAX_BYTES = 1472
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  input  logic        s_last,
  output logic        s_ready,
  input  logic [3:0]  tx_state,
  input  logic [8:0]  ram_rd_addr,
  output logic [31:0] datain,
  output logic [15:0] tx_data_length,
  output logic [15:0] tx_total_length,
  output logic        frame_ready,
  output logic        overflow
);

  localparam logic [11:0] MAX_CNT = 12'(MAX_BYTES);

  buf_state_t  state;
  logic [11:0] byte_cnt;
  logic [31:0] word_buf;
  logic        seen_crc;

  logic        acc;
  logic        drop;
  logic [1:0]  lane;
  logic [31:0] packed_word;
  logic        wr_en;
  logic [8:0]  wr_addr;
  logic [31:0] wr_data;
  logic [15:0] payload_len;

`ifdef UDP_MIN_PAD_EN
  localparam logic [8:0] PAD_LAST_ADDR = PAYLOAD_BASE_ADDR + 9'((MIN_PAYLOAD - 1) / 4);
  logic [8:0]  pad_addr;
  logic [11:0] final_cnt;
  assign final_cnt = drop ? byte_cnt : byte_cnt + 12'd1;
`endif

  assign acc         = s_valid && s_ready && (state == ST_FILL);
  assign drop        = acc && (byte_cnt == MAX_CNT);
  assign lane        = byte_cnt[1:0];
  assign packed_word = pack_lane(word_buf, lane, s_data);

  always_comb begin
    wr_en   = 1'b0;
    wr_addr = PAYLOAD_BASE_ADDR + 9'(byte_cnt[10:2]);
    wr_data = packed_word;
    if (acc && !drop) begin
      wr_en = (lane == 2'd3) || s_last;
    end else if (drop && s_last && (lane != 2'd0)) begin
      // Flush the partial word still held when the terminating byte is itself dropped.
      wr_en   = 1'b1;
      wr_data = word_buf;
    end
`ifdef UDP_MIN_PAD_EN
    else if ((state == ST_PAD) && (pad_addr <= PAD_LAST_ADDR)) begin
      wr_en   = 1'b1;
      wr_addr = pad_addr;
      wr_data = 32'h0;
    end
`endif
  end

  always_comb begin
`ifdef UDP_MIN_PAD_EN
    payload_len = (byte_cnt < 12'(MIN_PAYLOAD)) ? 16'(MIN_PAYLOAD) : {4'h0, byte_cnt};
`else
    payload_len = {4'h0, byte_cnt};
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= ST_FILL;
      s_ready         <= 1'b0;
      byte_cnt        <= 12'd0;
      word_buf        <= 32'h0;
      seen_crc        <= 1'b0;
      tx_data_length  <= 16'd26;
      tx_total_length <= 16'd46;
      frame_ready     <= 1'b0;
      overflow        <= 1'b0;
`ifdef UDP_MIN_PAD_EN
      pad_addr        <= PAYLOAD_BASE_ADDR;
`endif
    end else begin
      overflow <= drop;
      case (state)
        ST_FILL: begin
          if (acc && !drop) begin
            byte_cnt <= byte_cnt + 12'd1;
            word_buf <= packed_word;
          end
          if (acc && s_last) begin
            s_ready <= 1'b0;
`ifdef UDP_MIN_PAD_EN
            if (final_cnt < 12'(MIN_PAYLOAD - 1)) begin
              state    <= ST_PAD;
              pad_addr <= PAYLOAD_BASE_ADDR + 9'((final_cnt + 12'd3) >> 2);
            end else begin
              state <= ST_COMMIT;
            end
`else
            state <= ST_COMMIT;
`endif
          end else begin
            s_ready <= (tx_state == TX_IDLE);
          end
        end
`ifdef UDP_MIN_PAD_EN
        ST_PAD: begin
          if (pad_addr > PAD_LAST_ADDR) state <= ST_COMMIT;
          else                          pad_addr <= pad_addr + 9'd1;
        end
`endif
        ST_COMMIT: begin
          tx_data_length  <= 16'(UDP_HDR_LEN) + payload_len;
          tx_total_length <= 16'(UDP_HDR_LEN + IP_HDR_LEN) + payload_len;
          byte_cnt        <= 12'd0;
          frame_ready     <= 1'b1;
          state           <= ST_HOLD;
        end
        ST_HOLD: begin
          if (tx_state != TX_IDLE) begin
            frame_ready <= 1'b0;
            seen_crc    <= 1'b0;
            state       <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (tx_state == TX_SENDCRC) seen_crc <= 1'b1;
          if (seen_crc && (tx_state == TX_IDLE)) begin
            state   <= ST_FILL;
            s_ready <= 1'b1;
          end
        end
        default: begin
          state   <= ST_FILL;
          s_ready <= 1'b0;
        end
      endcase
    end
  end

  udp_payload_ram u_ram (
    .clk     (clk),
    .rst     (rst),
    .we      (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (ram_rd_addr),
    .rd_data (datain)
  );

endmodule

// File: tb/tb_udp_payload_buffer.sv
// Directed self-checking bench for udp_payload_buffer (default build, MAX_BYTES = 1472).
module tb_udp_payload_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_last;
  logic        s_ready;
  logic [3:0]  tx_state;
  logic [8:0]  ram_rd_addr;
  logic [31:0] datain;
  logic [15:0] tx_data_length;
  logic [15:0] tx_total_length;
  logic        frame_ready;
  logic        overflow;

  int n_cmp = 0;
  int n_err = 0;
  int ovf_cnt = 0;

  always #5 clk = ~clk;

  udp_payload_buffer #(.MAX_BYTES(1472)) dut (
    .clk             (clk),
    .rst             (rst),
    .s_data          (s_data),
    .s_valid         (s_valid),
    .s_last          (s_last),
    .s_ready         (s_ready),
    .tx_state        (tx_state),
    .ram_rd_addr     (ram_rd_addr),
    .datain          (datain),
    .tx_data_length  (tx_data_length),
    .tx_total_length (tx_total_length),
    .frame_ready     (frame_ready),
    .overflow        (overflow)
  );

  always @(negedge clk) if (overflow) ovf_cnt++;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input logic last);
    int guard = 0;
    s_data  = d;
    s_valid = 1'b1;
    s_last  = last;
    while (!s_ready && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 100) check_eq("s_ready_timeout", 32'(s_ready), 32'd1);
    @(posedge clk); #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic read_word(input logic [8:0] a, output logic [31:0] w);
    ram_rd_addr = a;
    @(posedge clk); #1;
    w = datain;
  endtask

  // Finish the handshake after s_last: COMMIT cycle, then HOLD with lengths published.
  task automatic check_commit(input string tag, input logic [15:0] dl, input logic [15:0] tl);
    check_eq({tag, "_commit_frame_ready"}, 32'(frame_ready), 32'd0);
    check_eq({tag, "_commit_s_ready"}, 32'(s_ready), 32'd0);
    @(posedge clk); #1;
    check_eq({tag, "_frame_ready"}, 32'(frame_ready), 32'd1);
    check_eq({tag, "_data_len"}, 32'(tx_data_length), 32'(dl));
    check_eq({tag, "_total_len"}, 32'(tx_total_length), 32'(tl));
  endtask

  task automatic run_tx(input string tag, input logic [15:0] dl, input logic [15:0] tl);
    logic [3:0] seq [4] = '{4'd5, 4'd6, 4'd7, 4'd0};
    for (int i = 0; i < 4; i++) begin
      tx_state = seq[i];
      @(posedge clk); #1;
      if (i < 3) begin
        check_eq({tag, "_busy_s_ready"}, 32'(s_ready), 32'd0);
        check_eq({tag, "_busy_frame_ready"}, 32'(frame_ready), 32'd0);
        check_eq({tag, "_busy_data_len"}, 32'(tx_data_length), 32'(dl));
        check_eq({tag, "_busy_total_len"}, 32'(tx_total_length), 32'(tl));
      end
    end
    check_eq({tag, "_refill_s_ready"}, 32'(s_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] w;
    logic [31:0] snap369;
    int ovf_base;

    rst = 1'b1; s_data = 8'h0; s_valid = 1'b0; s_last = 1'b0;
    tx_state = 4'd0; ram_rd_addr = 9'd0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_s_ready", 32'(s_ready), 32'd0);
    check_eq("rst_frame_ready", 32'(frame_ready), 32'd0);
    check_eq("rst_overflow", 32'(overflow), 32'd0);
    check_eq("rst_datain", datain, 32'h0);
    check_eq("rst_data_len", 32'(tx_data_length), 32'd26);
    check_eq("rst_total_len", 32'(tx_total_length), 32'd46);
    rst = 1'b0;
    @(posedge clk); #1;
    check_eq("post_rst_s_ready", 32'(s_ready), 32'd1);

    // 8 bytes 0x01..0x08
    for (int i = 1; i <= 8; i++) send_byte(8'(i), i == 8);
    check_commit("f8", 16'd16, 16'd36);
    check_eq("f8_hold_s_ready", 32'(s_ready), 32'd0);
    read_word(9'd1, w); check_eq("f8_ram1", w, 32'h01020304);
    read_word(9'd2, w); check_eq("f8_ram2", w, 32'h05060708);
    run_tx("f8", 16'd16, 16'd36);

    // 5 bytes 0xA1..0xA5 with a transmitter stall in the middle
    send_byte(8'hA1, 1'b0);
    send_byte(8'hA2, 1'b0);
    tx_state = 4'd3;
    @(posedge clk); #1;
    check_eq("f5_stall_s_ready", 32'(s_ready), 32'd0);
    tx_state = 4'd0;
    send_byte(8'hA3, 1'b0);
    send_byte(8'hA4, 1'b0);
    send_byte(8'hA5, 1'b1);
    check_commit("f5", 16'd13, 16'd33);
    read_word(9'd1, w); check_eq("f5_ram1", w, 32'hA1A2A3A4);
    read_word(9'd2, w); check_eq("f5_ram2", w, 32'hA5000000);
    run_tx("f5", 16'd13, 16'd33);

    // MAX_BYTES + 3 bytes: last three dropped, frame still commits
    read_word(9'd369, snap369);
    ovf_base = ovf_cnt;
    for (int i = 0; i < 1475; i++) send_byte(8'(i), i == 1474);
    check_commit("ovf", 16'd1480, 16'd1500);
    check_eq("ovf_pulses", 32'(ovf_cnt - ovf_base), 32'd3);
    read_word(9'd1, w);   check_eq("ovf_ram1", w, 32'h00010203);
    read_word(9'd368, w); check_eq("ovf_ram368", w, 32'hBCBDBEBF);
    read_word(9'd369, w); check_eq("ovf_ram369_untouched", w, snap369);
    run_tx("ovf", 16'd1480, 16'd1500);

    // Reset after three bytes, then a fresh frame
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0);
    check_eq("mid_data_len_stable", 32'(tx_data_length), 32'd1480);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_eq("mid_rst_s_ready", 32'(s_ready), 32'd0);
    check_eq("mid_rst_frame_ready", 32'(frame_ready), 32'd0);
    check_eq("mid_rst_data_len", 32'(tx_data_length), 32'd26);
    check_eq("mid_rst_total_len", 32'(tx_total_length), 32'd46);
    for (int i = 0; i < 4; i++) send_byte(8'hC1 + 8'(i), i == 3);
    check_commit("fresh", 16'd12, 16'd32);
    read_word(9'd1, w); check_eq("fresh_ram1", w, 32'hC1C2C3C4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, want finish before 2 ms");
    $fatal(1);
  end

endmodule
